// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, types and rotation/parity helpers
package des_pkg;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] subkey_t;

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT, DONE} state_t;

  // PC-1 tables: 1-based DES key bit numbers, bit 1 is key[63]
  localparam int PC1_C [28] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36
  };
  localparam int PC1_D [28] = '{
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2 table: 1-based bit numbers into the 56-bit C||D, bit 1 is C[27]
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Per-round rotation amounts; they sum to 28, so C16/D16 equal C0/D0
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic half_key_t rotl(input half_key_t x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic half_key_t rotr(input half_key_t x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // True when every key byte has odd parity
  function automatic logic key_parity_ok(input logic [63:0] k);
    return (^k[63:56]) & (^k[55:48]) & (^k[47:40]) & (^k[39:32]) &
           (^k[31:24]) & (^k[23:16]) & (^k[15:8])  & (^k[7:0]);
  endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational DES PC-2 permutation, 56-bit C||D to 48-bit subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output subkey_t     subkey
);

  // Pick the 48 PC-2 bits; output bit 1 lands in subkey[47]
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2[i])];
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - sequential DES key schedule, one subkey per handshake; optional DES_KEY_PARITY_CHECK_EN
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        start,
  output subkey_t     subkey,
  output logic        subkey_valid,
  input  logic        ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  state_t    state_q, state_d;
  half_key_t c_q, d_q;
  half_key_t c_pc1, d_pc1;
  half_key_t c_nxt, d_nxt;
  subkey_t   subkey_q, pc2_out;
  logic [3:0] round_q;
  logic      dec_q;
  logic      key_bad;
  logic      last_round;
  logic      xfer;
  logic      load_start;
  logic      load_step;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr_q;
  assign key_bad = ~key_parity_ok(key);
`else
  assign key_bad = 1'b0;
`endif

  // PC-1: split the 64-bit key into the 28-bit C and D halves, parity bits dropped
  always_comb begin
    c_pc1 = '0;
    d_pc1 = '0;
    for (int i = 0; i < 28; i++) begin
      c_pc1[5'(27 - i)] = key[6'(64 - PC1_C[i])];
      d_pc1[5'(27 - i)] = key[6'(64 - PC1_D[i])];
    end
  end

  assign last_round = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);
  assign load_start = (state_q == IDLE) && start && !key_bad;
  assign load_step  = xfer && !last_round;

  // Next C/D: fresh PC-1 load at start, otherwise step one round in the captured direction
  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (state_q == IDLE) begin
      if (decrypt) begin
        c_nxt = c_pc1;
        d_nxt = d_pc1;
      end else begin
        c_nxt = rotl(c_pc1, SHIFTS[0]);
        d_nxt = rotl(d_pc1, SHIFTS[0]);
      end
    end else if (dec_q) begin
      c_nxt = rotr(c_q, SHIFTS[round_q]);
      d_nxt = rotr(d_q, SHIFTS[round_q]);
    end else begin
      c_nxt = rotl(c_q, SHIFTS[round_q + 4'd1]);
      d_nxt = rotl(d_q, SHIFTS[round_q + 4'd1]);
    end
  end

  // Subkey is registered from the C/D value being loaded, so it is ready with the new state
  des_pc2 u_pc2 (
    .cd     ({c_nxt, d_nxt}),
    .subkey (pc2_out)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; LOAD is the single bubble between subkeys
  always_comb begin
    state_d      = state_q;
    subkey_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = key_bad ? DONE : PRESENT;
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        busy         = 1'b1;
        subkey_valid = 1'b1;
        if (ready) begin
          xfer    = 1'b1;
          state_d = last_round ? DONE : LOAD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key halves, direction, round index and registered subkey
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q      <= '0;
      d_q      <= '0;
      subkey_q <= '0;
      round_q  <= 4'd0;
      dec_q    <= 1'b0;
    end else if (load_start) begin
      c_q      <= c_nxt;
      d_q      <= d_nxt;
      subkey_q <= pc2_out;
      round_q  <= decrypt ? 4'd15 : 4'd0;
      dec_q    <= decrypt;
    end else if (load_step) begin
      c_q      <= c_nxt;
      d_q      <= d_nxt;
      subkey_q <= pc2_out;
      round_q  <= dec_q ? (round_q - 4'd1) : (round_q + 4'd1);
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  // Parity error flag, refreshed on every accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         perr_q <= 1'b0;
    else if ((state_q == IDLE) && start) perr_q <= key_bad;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign subkey = subkey_q;
  assign round  = round_q;

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - self-checking bench for des_key_sched against a bit-list DES key schedule model
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key = 64'h0;
  logic        decrypt = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        parity_err;

  int vectors = 0;
  int errors  = 0;

  localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_KNOWN  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_KNOWN = 48'hCB3D8B0E17F5;

  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TB_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_k [16];
  logic [47:0] got_k [$];
  int          got_r [$];
  int          done_cnt, done_cyc;
  logic        first_valid, first_busy, first_perr, busy_at_done;

  des_key_sched dut (
    .clk          (clk),
    .reset        (rst_n),
    .key          (key),
    .decrypt      (decrypt),
    .start        (start),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .ready        (ready),
    .round        (round),
    .busy         (busy),
    .done         (done),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // Textbook schedule: Kn uses C0/D0 rotated left by the cumulative shift total
  function automatic void model(input logic [63:0] k);
    bit kb [65];
    bit c0 [28];
    bit d0 [28];
    bit cd [56];
    int tot;
    logic [47:0] ks;
    for (int i = 1; i <= 64; i++) kb[i] = k[64 - i];
    for (int j = 0; j < 28; j++) begin
      c0[j] = kb[TB_PC1[j]];
      d0[j] = kb[TB_PC1[28 + j]];
    end
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += TB_SH[r];
      for (int j = 0; j < 28; j++) begin
        cd[j]      = c0[(j + tot) % 28];
        cd[28 + j] = d0[(j + tot) % 28];
      end
      for (int i = 0; i < 48; i++) ks[47 - i] = cd[TB_PC2[i] - 1];
      exp_k[r] = ks;
    end
  endfunction

  function automatic logic [63:0] odd_parity(input logic [63:0] k);
    logic [63:0] o;
    logic [7:0] b;
    o = k;
    for (int i = 0; i < 8; i++) begin
      b = o[i*8 +: 8];
      b[0] = ~^b[7:1];
      o[i*8 +: 8] = b;
    end
    return o;
  endfunction

  // Start a schedule and record every transfer; stall/poke options add backpressure or a stray start
  task automatic run_sched(input logic [63:0] k, input logic dec, input bit rand_ready,
                           input int stall_round, input int stall_len, input int poke_round);
    int cyc, post, stall_left;
    bit stalled, poked;
    logic [47:0] hk;
    logic [3:0]  hr;
    got_k.delete();
    got_r.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1;
    stall_left = 0; stalled = 0; poked = 0; hk = '0; hr = '0;
    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_valid = subkey_valid; first_busy = busy; first_perr = parity_err;
    cyc = 0; post = -1;
    while (cyc < 400 && post != 0) begin
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; post = 4; end
      end
      if (subkey_valid) begin
        if (stall_len > 0 && !stalled && int'(round) == stall_round) begin
          stalled = 1; hk = subkey; hr = round; stall_left = stall_len - 1; ready = 1'b0;
        end else if (stall_left > 0) begin
          vectors++;
          if (subkey !== hk || round !== hr) begin
            errors++;
            $display("FAIL stall_hold: subkey=%h round=%0d, required subkey=%h round=%0d", subkey, round, hk, hr);
          end
          stall_left--; ready = 1'b0;
        end else begin
          ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (ready) begin got_k.push_back(subkey); got_r.push_back(int'(round)); end
        end
        if (!poked && int'(round) == poke_round) begin
          poked = 1; start = 1'b1; key = ~key; decrypt = ~decrypt;
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
      if (post > 0) post--;
    end
    ready = 1'b0;
  endtask

  task automatic check_sequence(input string name, input logic dec);
    int idx;
    vectors++;
    if (got_k.size() != 16) begin
      errors++;
      $display("FAIL %s_count: transfers=%0d, required 16", name, got_k.size());
    end
    for (int i = 0; i < got_k.size() && i < 16; i++) begin
      idx = dec ? 15 - i : i;
      vectors++;
      if (got_k[i] !== exp_k[idx] || got_r[i] != idx) begin
        errors++;
        $display("FAIL %s_xfer%0d: subkey=%h round=%0d, required subkey=%h round=%0d",
                 name, i, got_k[i], got_r[i], exp_k[idx], idx);
      end
    end
    vectors++;
    if (done_cnt != 1 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d busy=%b, required 1 pulse busy=0", name, done_cnt, busy_at_done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({subkey, subkey_valid, round, busy, done, parity_err} !== 56'h0) begin
      errors++;
      $display("FAIL reset_state: subkey=%h valid=%b round=%0d busy=%b done=%b perr=%b, required all 0",
               subkey, subkey_valid, round, busy, done, parity_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt_known;
    model(KNOWN_KEY);
    run_sched(KNOWN_KEY, 1'b0, 1'b0, -1, 0, -1);
    vectors++;
    if (first_valid !== 1'b1 || first_busy !== 1'b1) begin
      errors++;
      $display("FAIL enc_latency: valid=%b busy=%b one cycle after start, required 1 1", first_valid, first_busy);
    end
    vectors++;
    if (got_k.size() < 16 || got_k[0] !== K1_KNOWN || got_r[0] != 0 || got_k[15] !== K16_KNOWN || got_r[15] != 15) begin
      errors++;
      $display("FAIL enc_known: transfers=%0d, required K1=%h@0 K16=%h@15", got_k.size(), K1_KNOWN, K16_KNOWN);
    end
    vectors++;
    if (done_cyc != 31) begin
      errors++;
      $display("FAIL enc_throughput: done at cycle %0d after first subkey, required 31", done_cyc);
    end
    vectors++;
    if (subkey !== K16_KNOWN) begin
      errors++;
      $display("FAIL enc_hold_last: subkey=%h, required %h", subkey, K16_KNOWN);
    end
    check_sequence("enc", 1'b0);
  endtask

  task automatic test_decrypt_known;
    model(KNOWN_KEY);
    run_sched(KNOWN_KEY, 1'b1, 1'b0, -1, 0, -1);
    vectors++;
    if (got_k.size() < 16 || got_k[0] !== K16_KNOWN || got_r[0] != 15 || got_k[15] !== K1_KNOWN || got_r[15] != 0) begin
      errors++;
      $display("FAIL dec_known: transfers=%0d, required K16=%h@15 first, K1=%h@0 last", got_k.size(), K16_KNOWN, K1_KNOWN);
    end
    check_sequence("dec", 1'b1);
  endtask

  task automatic test_backpressure;
    logic [63:0] k;
    k = odd_parity({$urandom, $urandom});
    model(k);
    run_sched(k, 1'b0, 1'b0, 3, 5, -1);
    vectors++;
    if (done_cyc != 36) begin
      errors++;
      $display("FAIL bp_timing: done at cycle %0d, required 36", done_cyc);
    end
    check_sequence("bp", 1'b0);
  endtask

  task automatic test_start_ignored;
    logic [63:0] k;
    k = odd_parity({$urandom, $urandom});
    model(k);
    run_sched(k, 1'b0, 1'b0, -1, 0, 7);
    check_sequence("start_ignored", 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [63:0] k;
    int n;
    bit seen_done;
    k = odd_parity({$urandom, $urandom});
    @(negedge clk);
    key = k; decrypt = 1'b0; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(subkey_valid && round == 4'd9) && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 100) begin
      errors++;
      $display("FAIL rst_mid_reach: round 9 not presented within 100 cycles, round=%0d", round);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({subkey, subkey_valid, round, busy, done, parity_err} !== 56'h0) begin
      errors++;
      $display("FAIL rst_mid_async: subkey=%h valid=%b round=%0d busy=%b done=%b, required all 0",
               subkey, subkey_valid, round, busy, done);
    end
    seen_done = 0;
    repeat (4) begin @(negedge clk); if (done || busy || subkey_valid) seen_done = 1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) seen_done = 1; end
    vectors++;
    if (seen_done) begin
      errors++;
      $display("FAIL rst_mid_quiet: done/busy/valid seen after abort, required none");
    end
    k = odd_parity({$urandom, $urandom});
    model(k);
    run_sched(k, 1'b0, 1'b0, -1, 0, -1);
    check_sequence("after_reset", 1'b0);
  endtask

  task automatic test_random;
    logic [63:0] k;
    logic dec;
    for (int it = 0; it < 6; it++) begin
      k = odd_parity({$urandom, $urandom});
      dec = 1'($urandom_range(0, 1));
      model(k);
      run_sched(k, dec, 1'b1, -1, 0, -1);
      check_sequence("random", dec);
    end
  endtask

  task automatic test_parity;
`ifdef DES_KEY_PARITY_CHECK_EN
    int valids, dones;
    bit perr_seen, perr_held;
    @(negedge clk);
    key = 64'h0; decrypt = 1'b0; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    perr_seen = parity_err;
    valids = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (subkey_valid) valids++;
      if (done) dones++;
      @(negedge clk);
    end
    perr_held = parity_err;
    vectors++;
    if (!perr_seen || !perr_held || valids != 0 || dones != 1) begin
      errors++;
      $display("FAIL parity_bad: perr=%b held=%b valids=%0d dones=%0d, required 1 1 0 1",
               perr_seen, perr_held, valids, dones);
    end
    model(KNOWN_KEY);
    run_sched(KNOWN_KEY, 1'b0, 1'b0, -1, 0, -1);
    vectors++;
    if (first_perr !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: perr=%b/%b, required 0", first_perr, parity_err);
    end
    check_sequence("parity_good", 1'b0);
`else
    model(64'h0);
    run_sched(64'h0, 1'b0, 1'b0, -1, 0, -1);
    vectors++;
    if (first_perr !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_off: perr=%b/%b, required 0", first_perr, parity_err);
    end
    check_sequence("parity_off", 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_encrypt_known();
    test_decrypt_known();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
